// File: rtl/periph_rx_arbiter.sv
// periph_rx_arbiter: drains the per-slot RX FIFOs into the single USB TX FIFO
// using burst-limited round-robin. Each packet is tagged with its slot address.
module periph_rx_arbiter #(
  parameter int unsigned NUM_PERIPHS = 8,
  parameter int unsigned DATA_WIDTH  = 29,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PERIPHS*DATA_WIDTH-1:0] periph_data,
  input  logic [NUM_PERIPHS-1:0]            periph_empty,
  output logic [NUM_PERIPHS-1:0]            periph_rden,
  input  logic [NUM_PERIPHS-1:0]            periph_enable,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]  out_data,
  output logic                              out_wren,
  input  logic                              out_full,
  output logic                              idle
);

  localparam int unsigned PKT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned SLOTS = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  logic                   r_hold_valid;
  logic [PKT_W-1:0]       r_hold_data;
  logic [ADDR_WIDTH-1:0]  r_last_grant;
  logic [CNT_W-1:0]       r_burst_cnt;

  logic [NUM_PERIPHS-1:0] w_req;
  logic [SLOTS-1:0]       w_req_ext;
  logic [DATA_WIDTH-1:0]  w_words [SLOTS];
  logic                   w_slot_free;
  logic                   w_grant_vld;
  logic                   w_stay;
  logic                   w_found;
  logic [ADDR_WIDTH-1:0]  w_scan;
  logic [ADDR_WIDTH-1:0]  w_grant;

  assign w_req       = ~periph_empty & periph_enable;
  assign w_req_ext   = SLOTS'(w_req);
  // Reset suppresses both strobes so nothing is popped or written on the reset edge.
  assign out_wren    = r_hold_valid & ~out_full & ~rst;
  assign w_slot_free = ~r_hold_valid | out_wren;
  assign w_grant_vld = w_slot_free & (|w_req) & ~rst;
  assign out_data    = r_hold_data;
  assign idle        = ~r_hold_valid & ~(|w_req);
  assign periph_rden = w_grant_vld ? (NUM_PERIPHS'(1) << w_grant) : '0;

  // Unpack the flat head-word bus into an address-indexed array.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      w_words[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_PERIPHS; i++) begin
      w_words[i] = periph_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant select: continue an open burst, else first requester after the last owner.
  // A zero burst count means no burst is open (post-reset), so slot 0 wins first.
  always_comb begin
    w_stay  = (r_burst_cnt != '0) && (r_burst_cnt < CNT_W'(MAX_BURST)) &&
              w_req_ext[r_last_grant];
    w_scan  = r_last_grant;
    w_grant = r_last_grant;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_PERIPHS; k++) begin
      w_scan = (w_scan == ADDR_WIDTH'(NUM_PERIPHS - 1)) ? '0 : w_scan + ADDR_WIDTH'(1);
      if (!w_found && w_req_ext[w_scan]) begin
        w_found = 1'b1;
        w_grant = w_scan;
      end
    end
    if (w_stay) begin
      w_grant = r_last_grant;
    end
  end

  // Holding register and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_last_grant <= ADDR_WIDTH'(NUM_PERIPHS - 1);
      r_burst_cnt  <= '0;
    end else if (w_grant_vld) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= {w_grant, w_words[w_grant]};
      if (w_stay) begin
        r_burst_cnt <= (r_burst_cnt < CNT_W'(MAX_BURST)) ? r_burst_cnt + CNT_W'(1)
                                                         : r_burst_cnt;
      end else begin
        r_last_grant <= w_grant;
        r_burst_cnt  <= CNT_W'(1);
      end
    end else if (out_wren) begin
      r_hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// tb_periph_rx_arbiter: FIFO-emulating bench with a round-robin reference model
// feeding an expected-packet queue that a separate monitor drains.
module tb_periph_rx_arbiter;

  localparam int N  = 8;
  localparam int DW = 29;
  localparam int AW = 3;
  localparam int MB = 4;
  localparam int PW = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] periph_data;
  logic [N-1:0]  periph_empty;
  logic [N-1:0]  periph_rden;
  logic [N-1:0]  periph_enable;
  logic [PW-1:0] out_data;
  logic          out_wren;
  logic          out_full;
  logic          idle;

  periph_rx_arbiter #(.NUM_PERIPHS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .periph_data(periph_data), .periph_empty(periph_empty),
    .periph_rden(periph_rden), .periph_enable(periph_enable), .out_data(out_data),
    .out_wren(out_wren), .out_full(out_full), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo [N][$];
  logic [PW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner of the current burst, words granted in it, held packet.
  int m_last = N - 1;
  int m_run  = 0;
  bit m_hold = 0;
  int m_g;
  logic [N-1:0] rden_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      periph_empty[i] = (fifo[i].size() == 0);
      periph_data[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  // One clock: predict at negedge, compare, then advance the model at posedge.
  task automatic cycle();
    logic [N-1:0] req;
    logic [N-1:0] exp_rden;
    bit exp_wren, free, stay;
    drive_fifos();
    @(negedge clk);
    req      = ~periph_empty & periph_enable;
    exp_wren = m_hold && !out_full && !rst;
    free     = !m_hold || exp_wren;
    stay     = (m_run > 0) && (m_run < MB) && req[m_last];
    m_g      = -1;
    if (!rst && free && (req != 0)) begin
      if (stay) m_g = m_last;
      else begin
        for (int k = 1; k <= N; k++) begin
          if (m_g < 0 && req[(m_last + k) % N]) m_g = (m_last + k) % N;
        end
      end
    end
    exp_rden = (m_g >= 0) ? (N'(1) << m_g) : '0;
    check("rden", periph_rden, exp_rden);
    check("wren", out_wren, exp_wren);
    check("idle", idle, (!m_hold && req == 0));
    if (m_g >= 0) exp_q.push_back({AW'(m_g), fifo[m_g][0]});
    rden_seen = periph_rden;
    @(posedge clk);
    if (rst) begin
      m_hold = 0; m_last = N - 1; m_run = 0;
      exp_q.delete();
    end else if (m_g >= 0) begin
      m_hold = 1;
      if (stay) m_run++;
      else begin m_last = m_g; m_run = 1; end
    end else if (exp_wren) begin
      m_hold = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (rden_seen[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    end
    #1;
  endtask

  // Monitor: every write to the USB FIFO must match the oldest expected packet.
  always @(negedge clk) begin
    if (out_wren) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_data_unexpected: got %0h expected no write at %0t", out_data, $time);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  bit all_empty;
  logic [PW-1:0] held;
  int burst_order [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
  int mask_order  [9]  = '{7, 7, 7, 7, 0, 0, 0, 7, 7};

  initial begin
    rst = 1'b1; out_full = 1'b0; periph_enable = '1;
    cycle(); cycle();
    check("rst_out_data", out_data, '0);
    check("rst_idle", idle, 1'b1);
    rst = 1'b0;

    // Basic path
    fifo[2].push_back(29'h0ABCDEF);
    cycle();
    check("basic_rden", rden_seen, 8'b0000_0100);
    check("basic_data", out_data, 32'h40ABCDEF);
    cycle();
    check("basic_idle", idle, 1'b1);

    // Burst then rotate
    for (int i = 0; i < 6; i++) begin
      fifo[0].push_back(DW'(32'h100 + i));
      fifo[1].push_back(DW'(32'h200 + i));
    end
    for (int k = 0; k < 12; k++) begin
      cycle();
      check($sformatf("burst_order_%0d", k), m_g, burst_order[k]);
    end
    cycle();

    // Backpressure
    for (int i = 0; i < 3; i++) fifo[5].push_back(DW'(32'h500 + i));
    cycle();
    out_full = 1'b1;
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_stable", out_data, held);
    end
    out_full = 1'b0;
    for (int k = 0; k < 4; k++) cycle();

    // Mask and wrap
    periph_enable[0] = 1'b0;
    for (int i = 0; i < 6; i++) fifo[7].push_back(DW'(32'h700 + i));
    for (int i = 0; i < 3; i++) fifo[0].push_back(DW'(32'h0A0 + i));
    for (int k = 0; k < 9; k++) begin
      if (k == 2) periph_enable[0] = 1'b1;
      cycle();
      check($sformatf("mask_order_%0d", k), m_g, mask_order[k]);
    end
    cycle();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) fifo[3].push_back(DW'(32'h300 + i));
    cycle();
    fifo[0].push_back(DW'(32'h0B0));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_prio", m_g, 0);
    for (int k = 0; k < 4; k++) cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      out_full = ($urandom_range(0, 3) == 0);
      periph_enable = N'($urandom) | N'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (fifo[i].size() < 8 && $urandom_range(0, 5) == 0) fifo[i].push_back(DW'($urandom));
      end
      cycle();
    end
    rst = 1'b0; out_full = 1'b0; periph_enable = '1;
    for (int c = 0; c < 200; c++) begin
      all_empty = 1;
      for (int i = 0; i < N; i++) if (fifo[i].size() != 0) all_empty = 0;
      if (all_empty && !m_hold) break;
      cycle();
    end
    cycle();
    check("drain_queue", exp_q.size(), 0);
    check("drain_idle", idle, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
